// File: rtl/fpu_wb_arbiter_if.sv
// Bus between the FPU result sources and the writeback arbiter.
// The arbiter uses the slave modport and the result producers use the master modport.
interface fpu_wb_arbiter_if #(
  parameter int N_SRC = 14,
  parameter int N_WP  = 2
);
  logic [N_SRC-1:0]    src_valid;
  logic [N_SRC*5-1:0]  src_rd;
  logic [N_SRC*32-1:0] src_data;
  logic [N_WP-1:0]     wb_valid;
  logic [N_WP*5-1:0]   wb_rd;
  logic [N_WP*32-1:0]  wb_data;
  logic                stall;
  logic                overflow;
  logic                busy;

  modport master (
    output src_valid, src_rd, src_data,
    input  wb_valid, wb_rd, wb_data, stall, overflow, busy
  );

  modport slave (
    input  src_valid, src_rd, src_data,
    output wb_valid, wb_rd, wb_data, stall, overflow, busy
  );
endinterface

// File: rtl/fpu_wb_arbiter.sv
// Funnels results from N_SRC fixed-latency FPU pipelines onto N_WP GPR write ports.
// Each source owns a small FIFO; a rotating-priority arbiter drains up to N_WP heads per cycle.
module fpu_wb_arbiter #(
  parameter int N_SRC  = 14,
  parameter int DEPTH  = 4,
  parameter int N_WP   = 2,
  parameter int ALMOST = 2
) (
  input  logic             clk,
  input  logic             rstn,
  fpu_wb_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(N_SRC);
  localparam int ENT_W = 37;

  logic [IDX_W-1:0]     r_rr;
  logic [N_WP-1:0]      r_wb_valid;
  logic [N_WP*5-1:0]    r_wb_rd;
  logic [N_WP*32-1:0]   r_wb_data;
  logic                 r_overflow;

  logic [N_SRC-1:0]     w_nonempty;
  logic [N_SRC-1:0]     w_almost;
  logic [N_SRC-1:0]     w_drop;
  logic [N_SRC-1:0]     w_pop;
  logic [ENT_W-1:0]     w_head [N_SRC];

  logic [2*N_SRC-1:0]   w_ne2;
  logic [2*N_SRC-1:0]   w_pop2;
  logic [N_SRC-1:0]     w_rot;
  logic [N_SRC-1:0]     w_rot_pop;
  logic [IDX_W:0]       w_gnt_cnt;
  logic [N_WP-1:0]      w_gnt_vld;
  logic [IDX_W-1:0]     w_gnt_dist [N_WP];
  logic [IDX_W-1:0]     w_gnt_idx  [N_WP];
  logic [IDX_W-1:0]     w_last_dist;
  logic [IDX_W:0]       w_rr_sum;
  logic [IDX_W-1:0]     w_rr_next;

  // Per-source FIFO: a full queue still accepts a push when it is popped in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_q
      logic [ENT_W-1:0] r_mem [DEPTH];
      logic [PTR_W-1:0] r_wptr;
      logic [PTR_W-1:0] r_rptr;
      logic [CNT_W-1:0] r_cnt;
      logic             w_full;
      logic             w_push;

      assign w_full         = (r_cnt == CNT_W'(DEPTH));
      assign w_push         = bus.src_valid[gi] & (~w_full | w_pop[gi]);
      assign w_drop[gi]     = bus.src_valid[gi] & w_full & ~w_pop[gi];
      assign w_nonempty[gi] = (r_cnt != '0);
      assign w_almost[gi]   = (r_cnt >= CNT_W'(DEPTH - ALMOST));
      assign w_head[gi]     = r_mem[r_rptr];

      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem[r_wptr] <= {bus.src_rd[5*gi +: 5], bus.src_data[32*gi +: 32]};
        end
      end

      always_ff @(posedge clk) begin
        if (!rstn) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else begin
          if (w_push) r_wptr <= r_wptr + PTR_W'(1);
          if (w_pop[gi]) r_rptr <= r_rptr + PTR_W'(1);
          case ({w_push, w_pop[gi]})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
          endcase
        end
      end
    end
  endgenerate

  // Rotate occupancy so that bit d is source (rr+d) mod N_SRC; priority is then plain LSB-first.
  assign w_ne2 = {w_nonempty, w_nonempty} >> r_rr;
  assign w_rot = w_ne2[N_SRC-1:0];

  always_comb begin
    w_rot_pop = '0;
    w_gnt_vld = '0;
    w_gnt_cnt = '0;
    for (int p = 0; p < N_WP; p++) w_gnt_dist[p] = '0;
    for (int d = 0; d < N_SRC; d++) begin
      if (w_rot[d]) begin
        for (int p = 0; p < N_WP; p++) begin
          if (w_gnt_cnt == (IDX_W+1)'(p)) begin
            w_gnt_vld[p]  = 1'b1;
            w_gnt_dist[p] = IDX_W'(d);
            w_rot_pop[d]  = 1'b1;
          end
        end
        w_gnt_cnt = w_gnt_cnt + (IDX_W+1)'(1);
      end
    end
  end

  // Undo the rotation: pop bit i comes from rotated position (i - rr) mod N_SRC.
  assign w_pop2 = {w_rot_pop, w_rot_pop} << r_rr;
  assign w_pop  = w_pop2[2*N_SRC-1:N_SRC];

  generate
    for (gi = 0; gi < N_WP; gi++) begin : g_idx
      logic [IDX_W:0] w_sum;
      assign w_sum = {1'b0, r_rr} + {1'b0, w_gnt_dist[gi]};
      assign w_gnt_idx[gi] = (w_sum >= (IDX_W+1)'(N_SRC)) ?
                             IDX_W'(w_sum - (IDX_W+1)'(N_SRC)) : w_sum[IDX_W-1:0];
    end
  endgenerate

  always_comb begin
    w_last_dist = '0;
    for (int p = 0; p < N_WP; p++) begin
      if (w_gnt_vld[p]) w_last_dist = w_gnt_dist[p];
    end
  end

  assign w_rr_sum  = {1'b0, r_rr} + {1'b0, w_last_dist} + (IDX_W+1)'(1);
  assign w_rr_next = (w_rr_sum >= (IDX_W+1)'(N_SRC)) ?
                     IDX_W'(w_rr_sum - (IDX_W+1)'(N_SRC)) : w_rr_sum[IDX_W-1:0];

  // Ungranted ports drop valid but keep their last rd/data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rr       <= '0;
      r_wb_valid <= '0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (|w_gnt_vld) r_rr <= w_rr_next;
      if (|w_drop) r_overflow <= 1'b1;
      r_wb_valid <= w_gnt_vld;
      for (int p = 0; p < N_WP; p++) begin
        if (w_gnt_vld[p]) begin
          r_wb_rd[5*p +: 5]    <= w_head[w_gnt_idx[p]][36:32];
          r_wb_data[32*p +: 32] <= w_head[w_gnt_idx[p]][31:0];
        end
      end
    end
  end

  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_rd    = r_wb_rd;
  assign bus.wb_data  = r_wb_data;
  assign bus.overflow = r_overflow;
  assign bus.stall    = |w_almost;
  assign bus.busy     = (|w_nonempty) | (|r_wb_valid);

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Directed bench for fpu_wb_arbiter: a queue-level reference model checked every cycle,
// plus hand-computed expectations for reset, single, burst, fairness, overflow and mid-op reset.
module tb_fpu_wb_arbiter;
  localparam int N_SRC  = 14;
  localparam int DEPTH  = 4;
  localparam int N_WP   = 2;
  localparam int ALMOST = 2;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_err;
  bit   chk_en;

  fpu_wb_arbiter_if #(.N_SRC(N_SRC), .N_WP(N_WP)) bus ();

  fpu_wb_arbiter #(.N_SRC(N_SRC), .DEPTH(DEPTH), .N_WP(N_WP), .ALMOST(ALMOST)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one queue per source, round-robin pointer, plain arithmetic.
  logic [36:0] mq [N_SRC][$];
  int          m_rr;
  logic [1:0]  exp_wb_valid;
  logic [9:0]  exp_wb_rd;
  logic [63:0] exp_wb_data;
  logic        exp_overflow;
  logic        exp_stall;
  logic        exp_busy;
  logic [36:0] m_ent;
  int          m_ng;
  int          m_last;

  initial begin
    m_rr = 0; exp_wb_valid = '0; exp_wb_rd = '0; exp_wb_data = '0;
    exp_overflow = 1'b0; exp_stall = 1'b0; exp_busy = 1'b0;
  end

  always @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < N_SRC; s++) mq[s].delete();
      m_rr = 0;
      exp_wb_valid = '0;
      exp_wb_rd = '0;
      exp_wb_data = '0;
      exp_overflow = 1'b0;
    end else begin
      m_ng = 0;
      m_last = 0;
      exp_wb_valid = '0;
      for (int d = 0; d < N_SRC; d++) begin
        int s;
        s = (m_rr + d) % N_SRC;
        if (m_ng < N_WP && mq[s].size() > 0) begin
          m_ent = mq[s].pop_front();
          exp_wb_valid[m_ng] = 1'b1;
          exp_wb_rd[5*m_ng +: 5] = m_ent[36:32];
          exp_wb_data[32*m_ng +: 32] = m_ent[31:0];
          m_last = s;
          m_ng++;
        end
      end
      if (m_ng > 0) m_rr = (m_last + 1) % N_SRC;
      for (int s = 0; s < N_SRC; s++) begin
        if (bus.src_valid[s]) begin
          if (mq[s].size() < DEPTH)
            mq[s].push_back({bus.src_rd[5*s +: 5], bus.src_data[32*s +: 32]});
          else
            exp_overflow = 1'b1;
        end
      end
    end
    exp_stall = 1'b0;
    exp_busy  = (exp_wb_valid != 0);
    for (int s = 0; s < N_SRC; s++) begin
      if (mq[s].size() >= DEPTH - ALMOST) exp_stall = 1'b1;
      if (mq[s].size() > 0) exp_busy = 1'b1;
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_wb_valid", 64'(bus.wb_valid), 64'(exp_wb_valid));
      chk("model_wb_rd",    64'(bus.wb_rd),    64'(exp_wb_rd));
      chk("model_wb_data",  bus.wb_data,       exp_wb_data);
      chk("model_stall",    64'(bus.stall),    64'(exp_stall));
      chk("model_overflow", 64'(bus.overflow), 64'(exp_overflow));
      chk("model_busy",     64'(bus.busy),     64'(exp_busy));
      for (int p = 0; p < N_WP; p++) begin
        if (bus.wb_valid[p])
          $display("t=%0t wb port%0d rd=%0d data=%08h", $time, p, bus.wb_rd[5*p +: 5],
                   bus.wb_data[32*p +: 32]);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr_src();
    bus.src_valid = '0;
  endtask

  task automatic pulse(input int s, input logic [4:0] rd, input logic [31:0] d);
    bus.src_valid[s] = 1'b1;
    bus.src_rd[5*s +: 5] = rd;
    bus.src_data[32*s +: 32] = d;
  endtask

  task automatic do_reset();
    clr_src();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (bus.busy && k < 40) begin
      cyc();
      k++;
    end
    chk(name, 64'(bus.busy), 64'd0);
  endtask

  logic [9:0]  pair_rd;
  logic [63:0] pair_data;
  int          seen1, seen9;

  initial begin
    n_checks = 0;
    n_err = 0;
    chk_en = 1'b0;
    rstn = 1'b0;
    bus.src_valid = '1;
    bus.src_rd = '1;
    bus.src_data = '1;

    // reset with every source pulsing
    cyc();
    cyc();
    chk_en = 1'b1;
    chk("reset_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("reset_overflow", 64'(bus.overflow), 64'd0);
    chk("reset_stall",    64'(bus.stall),    64'd0);
    chk("reset_busy",     64'(bus.busy),     64'd0);
    clr_src();
    rstn = 1'b1;
    cyc();

    // single result, two-cycle latency
    pulse(3, 5'd5, 32'h3F80_0000);
    cyc();
    clr_src();
    chk("single_t0_valid", 64'(bus.wb_valid), 64'd0);
    chk("single_t0_busy",  64'(bus.busy), 64'd1);
    cyc();
    chk("single_valid", 64'(bus.wb_valid), 64'h1);
    chk("single_rd",    64'(bus.wb_rd[4:0]), 64'd5);
    chk("single_data",  64'(bus.wb_data[31:0]), 64'h3F80_0000);
    cyc();
    chk("single_idle_valid", 64'(bus.wb_valid), 64'd0);
    chk("single_idle_busy",  64'(bus.busy), 64'd0);

    // burst from all sources
    do_reset();
    for (int i = 0; i < N_SRC; i++) pulse(i, 5'(i), 32'hA000_0000 + 32'(i));
    cyc();
    clr_src();
    for (int k = 0; k < 7; k++) begin
      cyc();
      pair_rd   = {5'(2*k+1), 5'(2*k)};
      pair_data = {32'hA000_0000 + 32'(2*k+1), 32'hA000_0000 + 32'(2*k)};
      chk("burst_valid", 64'(bus.wb_valid), 64'h3);
      chk("burst_rd",    64'(bus.wb_rd), 64'(pair_rd));
      chk("burst_data",  bus.wb_data, pair_data);
    end
    chk("burst_busy_last", 64'(bus.busy), 64'd1);
    cyc();
    chk("burst_busy_after", 64'(bus.busy), 64'd0);

    // fairness against two always-busy sources
    do_reset();
    seen1 = -1;
    seen9 = -1;
    for (int c = 0; c < 20; c++) begin
      pulse(0, 5'd10, 32'h1000_0000 + 32'(c));
      pulse(5, 5'd15, 32'h5000_0000 + 32'(c));
      if (c == 3) begin
        pulse(1, 5'd1, 32'h0000_0101);
        pulse(9, 5'd9, 32'h0000_0909);
      end
      cyc();
      clr_src();
      for (int p = 0; p < N_WP; p++) begin
        if (bus.wb_valid[p] && bus.wb_rd[5*p +: 5] == 5'd1 && seen1 < 0) seen1 = c;
        if (bus.wb_valid[p] && bus.wb_rd[5*p +: 5] == 5'd9 && seen9 < 0) seen9 = c;
      end
    end
    chk("fair_src1_in_3", 64'(seen1 >= 4 && seen1 <= 6), 64'd1);
    chk("fair_src9_in_3", 64'(seen9 >= 4 && seen9 <= 6), 64'd1);
    chk("fair_no_overflow", 64'(bus.overflow), 64'd0);
    drain("fair_drain");

    // stall then overflow under sustained four-way competition
    do_reset();
    for (int c = 0; c < 8; c++) begin
      pulse(0,  5'd20, 32'hC000_0000 + 32'(c));
      pulse(1,  5'd21, 32'hC100_0000 + 32'(c));
      pulse(2,  5'd22, 32'hC200_0000 + 32'(c));
      pulse(13, 5'd23, 32'hCD00_0000 + 32'(c));
      cyc();
      if (c == 0) chk("ovf_stall_early", 64'(bus.stall), 64'd0);
      if (c == 1) chk("ovf_stall_cnt2",  64'(bus.stall), 64'd1);
      if (c == 5) chk("ovf_none_6cyc",   64'(bus.overflow), 64'd0);
      if (c == 7) chk("ovf_set",         64'(bus.overflow), 64'd1);
    end
    clr_src();
    drain("ovf_drain");
    chk("ovf_sticky", 64'(bus.overflow), 64'd1);
    chk("ovf_stall_clear", 64'(bus.stall), 64'd0);

    // mid-operation reset discards queued entries
    do_reset();
    for (int i = 0; i < 5; i++) pulse(i, 5'(20 + i), 32'hDEAD_0000 + 32'(i));
    cyc();
    clr_src();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    chk("midrst_valid", 64'(bus.wb_valid), 64'd0);
    chk("midrst_busy",  64'(bus.busy), 64'd0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("midrst_no_stale", 64'(bus.wb_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
